// File: rtl/xy_route_lock.sv
// Per-input-port XY route decode and wormhole path lock.
// A head picks the output port, the allocator grant locks it, and the tail transfer releases it.
module xy_route_lock #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned X_W    = 2,
  parameter int unsigned Y_W    = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  output logic [2:0]        sel,
  output logic              req,
  input  logic              grant,
  output logic              err,
  output logic [15:0]       pkt_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  typedef struct packed {
    logic           is_head;
    logic           is_tail;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
  } hdr_t;

  localparam logic [2:0] SEL_L    = 3'b000;
  localparam logic [2:0] SEL_N    = 3'b001;
  localparam logic [2:0] SEL_E    = 3'b010;
  localparam logic [2:0] SEL_S    = 3'b011;
  localparam logic [2:0] SEL_W    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [X_W-1:0] MY_XV = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_YV = Y_W'(MY_Y);

  state_t     state;
  hdr_t       hdr;
  logic [2:0] route;
  logic       xfer;

  // Type bit 0 marks a head, bit 1 marks a tail; 11 is a single-flit packet.
  always_comb begin
    hdr.is_head = flit_in[FLIT_W-2];
    hdr.is_tail = flit_in[FLIT_W-1];
    hdr.dx      = flit_in[X_W+Y_W-1:Y_W];
    hdr.dy      = flit_in[Y_W-1:0];
  end

  // X is resolved fully before Y, which keeps the mesh deadlock-free.
  always_comb begin
    route = SEL_L;
    if (hdr.dx > MY_XV)      route = SEL_E;
    else if (hdr.dx < MY_XV) route = SEL_W;
    else if (hdr.dy > MY_YV) route = SEL_N;
    else if (hdr.dy < MY_YV) route = SEL_S;
  end

  always_comb begin
    flit_ready = 1'b0;
    case (state)
      IDLE:    flit_ready = flit_valid & ~hdr.is_head;
      ACTIVE:  flit_ready = out_ready;
      default: flit_ready = 1'b0;
    endcase
  end

  assign flit_out       = flit_in;
  assign flit_out_valid = (state == ACTIVE) & flit_valid & out_ready;
  assign xfer           = flit_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= SEL_NONE;
      req     <= 1'b0;
      err     <= 1'b0;
      pkt_cnt <= 16'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (flit_valid && hdr.is_head) begin
            sel   <= route;
            req   <= 1'b1;
            state <= REQ;
          end else if (flit_valid) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (grant) begin
            req   <= 1'b0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A head seen mid-packet is only a body here; just the tail bit matters.
          if (xfer && hdr.is_tail) begin
            sel     <= SEL_NONE;
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= IDLE;
          end
        end
        default: begin
          sel   <= SEL_NONE;
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xy_route_lock.sv
// Scenario bench for xy_route_lock on a router at (1,1), plus randomized packets checked against a packet-level model.
module tb_xy_route_lock;
  localparam int FW = 16;
  localparam int MX = 1;
  localparam int MY = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] flit_in = '0;
  logic          flit_valid = 1'b0;
  logic          flit_ready;
  logic          out_ready = 1'b0;
  logic [FW-1:0] flit_out;
  logic          flit_out_valid;
  logic [2:0]    sel;
  logic          req;
  logic          grant = 1'b0;
  logic          err;
  logic [15:0]   pkt_cnt;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  xy_route_lock #(.FLIT_W(FW), .X_W(2), .Y_W(2), .MY_X(MX), .MY_Y(MY)) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .out_ready(out_ready), .flit_out(flit_out),
    .flit_out_valid(flit_out_valid), .sel(sel), .req(req), .grant(grant),
    .err(err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (err) err_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [2:0] route(input int x, input int y);
    if (x > MX) return 3'b010;
    if (x < MX) return 3'b100;
    if (y > MY) return 3'b001;
    if (y < MY) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [1:0] xb, yb;
    xb = 2'(x);
    yb = 2'(y);
    return {t, 10'd0, xb, yb};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; flit_valid = 1'b0; flit_in = '0; grant = 1'b0; out_ready = 1'b0;
    tick;
    rst_n = 1'b1;
    err_seen = 0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (sel !== 3'b111) begin errors++; $display("FAIL reset_sel got %b want 111", sel); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL reset_fov got %b want 0", flit_out_valid); end
  endtask

  task automatic test_basic;
    do_reset;
    flit_in = 16'h400D; flit_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (flit_ready !== 1'b0) begin errors++; $display("FAIL basic_head_ready got %b want 0", flit_ready); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL basic_req_n got %b want 0", req); end
    tick; grant = 1'b1; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL basic_req_n1 got %b want 1", req); end
    checks++; if (sel !== 3'b010) begin errors++; $display("FAIL basic_sel_e got %b want 010", sel); end
    checks++; if (flit_ready !== 1'b0) begin errors++; $display("FAIL basic_req_ready got %b want 0", flit_ready); end
    tick; grant = 1'b0; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL basic_req_active got %b want 0", req); end
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== 16'h400D) begin errors++; $display("FAIL basic_head_fwd got %b/%h want 1/400d", flit_out_valid, flit_out); end
    tick; flit_in = 16'h0000; #1;
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== 16'h0000) begin errors++; $display("FAIL basic_body_fwd got %b/%h want 1/0000", flit_out_valid, flit_out); end
    tick; flit_in = 16'h8000; #1;
    checks++; if (flit_out_valid !== 1'b1 || sel !== 3'b010) begin errors++; $display("FAIL basic_tail_fwd got %b/%b want 1/010", flit_out_valid, sel); end
    tick; flit_valid = 1'b0; #1;
    checks++; if (sel !== 3'b111) begin errors++; $display("FAIL basic_sel_release got %b want 111", sel); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL basic_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_single_flit;
    int dx[4] = '{1, 1, 0, 1};
    int dy[4] = '{3, 0, 1, 1};
    logic [2:0] want[4] = '{3'b001, 3'b011, 3'b100, 3'b000};
    do_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flit_in = mk(2'b11, dx[i], dy[i]); flit_valid = 1'b1;
      tick; grant = 1'b1; #1;
      checks++; if (req !== 1'b1 || sel !== want[i]) begin errors++; $display("FAIL single_sel%0d got %b/%b want 1/%b", i, req, sel, want[i]); end
      tick; grant = 1'b0; #1;
      checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL single_fwd%0d got %b want 1", i, flit_out_valid); end
      tick; flit_valid = 1'b0; #1;
      checks++; if (sel !== 3'b111) begin errors++; $display("FAIL single_release%0d got %b want 111", i, sel); end
    end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL single_pkt_cnt got %0d want 4", pkt_cnt); end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL single_err got %0d want 0", err_seen); end
  endtask

  task automatic test_backpressure;
    do_reset;
    flit_in = mk(2'b01, 3, 1); flit_valid = 1'b1; out_ready = 1'b0;
    tick; grant = 1'b1;
    tick; grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (flit_ready !== 1'b0 || flit_out_valid !== 1'b0 || sel !== 3'b010) begin errors++; $display("FAIL bp_stall%0d got rdy=%b fov=%b sel=%b want 0/0/010", i, flit_ready, flit_out_valid, sel); end
      tick;
    end
    out_ready = 1'b1; #1;
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== mk(2'b01, 3, 1)) begin errors++; $display("FAIL bp_resume got %b/%h want 1/%h", flit_out_valid, flit_out, mk(2'b01, 3, 1)); end
    tick; flit_in = 16'h8000; #1;
    checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL bp_tail got %b want 1", flit_out_valid); end
    tick; flit_valid = 1'b0; #1;
    checks++; if (pkt_cnt !== 16'd1 || sel !== 3'b111) begin errors++; $display("FAIL bp_done got %0d/%b want 1/111", pkt_cnt, sel); end
  endtask

  task automatic test_stray;
    do_reset;
    flit_in = 16'h0005; flit_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (flit_ready !== 1'b1 || flit_out_valid !== 1'b0) begin errors++; $display("FAIL stray_pop got %b/%b want 1/0", flit_ready, flit_out_valid); end
    tick; flit_valid = 1'b0; #1;
    checks++; if (err !== 1'b1 || sel !== 3'b111 || req !== 1'b0) begin errors++; $display("FAIL stray_err got %b/%b/%b want 1/111/0", err, sel, req); end
    tick; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_pulse got %b want 0", err); end
  endtask

  task automatic test_grant_stall;
    do_reset;
    grant = 1'b1; #1;
    tick; grant = 1'b0; #1;
    checks++; if (req !== 1'b0 || sel !== 3'b111) begin errors++; $display("FAIL idle_grant got %b/%b want 0/111", req, sel); end
    flit_in = 16'h8000; flit_valid = 1'b1; #1;
    checks++; if (flit_ready !== 1'b1 || flit_out_valid !== 1'b0) begin errors++; $display("FAIL idle_grant_state got %b/%b want 1/0", flit_ready, flit_out_valid); end
    tick;
    flit_in = mk(2'b01, 1, 3); out_ready = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (req !== 1'b1 || flit_ready !== 1'b0) begin errors++; $display("FAIL stall%0d got req=%b rdy=%b want 1/0", i, req, flit_ready); end
      tick;
    end
    grant = 1'b1;
    tick; grant = 1'b0; flit_in = mk(2'b11, 1, 3); #1;
    checks++; if (flit_out_valid !== 1'b1 || sel !== 3'b001) begin errors++; $display("FAIL stall_release got %b/%b want 1/001", flit_out_valid, sel); end
    tick; flit_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    flit_in = mk(2'b01, 0, 1); flit_valid = 1'b1; out_ready = 1'b1;
    tick; grant = 1'b1;
    tick; grant = 1'b0;
    tick; flit_in = 16'h1234;
    tick; flit_valid = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (sel !== 3'b111 || req !== 1'b0) begin errors++; $display("FAIL rstmid_now got %b/%b want 111/0", sel, req); end
    tick; rst_n = 1'b1; err_seen = 0;
    flit_in = 16'h8000; flit_valid = 1'b1; #1;
    checks++; if (flit_ready !== 1'b1 || flit_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b/%b want 1/0", flit_ready, flit_out_valid); end
    tick; flit_valid = 1'b0; #1;
    checks++; if (err !== 1'b1 || pkt_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_err got %b/%0d want 1/0", err, pkt_cnt); end
    tick;
  endtask

  task automatic test_random;
    logic [FW-1:0] pk[$];
    logic [FW-1:0] f;
    logic [2:0] exp_sel;
    int npk, nstray, len, x, y, dly, rc, cyc, idx;
    npk = 0; nstray = 0;
    do_reset;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 4); x = $urandom_range(0, 3); y = $urandom_range(0, 3);
      dly = $urandom_range(0, 3); rc = 0; cyc = 0; idx = 0;
      exp_sel = route(x, y);
      pk.delete();
      for (int i = 0; i < len; i++) begin
        f = 16'($urandom);
        if (i == 0) begin
          f[15:14] = (len == 1) ? 2'b11 : 2'b01;
          f[3:0] = {2'(x), 2'(y)};
        end else if (i == len - 1) f[15:14] = 2'b10;
        else f[15:14] = {1'b0, 1'($urandom)};
        pk.push_back(f);
      end
      while (idx < len && cyc < 300) begin
        flit_in = pk[idx]; flit_valid = 1'b1; out_ready = ($urandom_range(0, 3) != 0);
        if (req) rc++;
        grant = req && (rc > dly);
        #1;
        checks++; if (flit_out_valid !== (flit_valid && flit_ready)) begin errors++; $display("FAIL rnd_pop p%0d got fov=%b rdy=%b", p, flit_out_valid, flit_ready); end
        if (!out_ready && flit_out_valid) begin checks++; errors++; $display("FAIL rnd_bp p%0d fov=1 with out_ready=0", p); end
        if (flit_out_valid) begin
          checks++; if (flit_out !== pk[idx] || sel !== exp_sel) begin errors++; $display("FAIL rnd_fwd p%0d got %h/%b want %h/%b", p, flit_out, sel, pk[idx], exp_sel); end
        end
        if (req) begin
          checks++; if (sel !== exp_sel) begin errors++; $display("FAIL rnd_req_sel p%0d got %b want %b", p, sel, exp_sel); end
        end
        if (flit_valid && flit_ready) idx++;
        tick; cyc++;
      end
      grant = 1'b0; flit_valid = 1'b0;
      if (idx < len) begin checks++; errors++; $display("FAIL rnd_timeout p%0d got %0d flits want %0d", p, idx, len); end
      npk++;
      if ($urandom_range(0, 3) == 0) begin
        flit_in = 16'($urandom); flit_in[14] = 1'b0; flit_valid = 1'b1; nstray++;
      end
      #1;
      checks++; if (sel !== 3'b111 || flit_out_valid !== 1'b0 || flit_ready !== flit_valid) begin errors++; $display("FAIL rnd_idle p%0d got sel=%b fov=%b rdy=%b", p, sel, flit_out_valid, flit_ready); end
      tick; flit_valid = 1'b0;
    end
    tick; #1;
    checks++; if (pkt_cnt !== 16'(npk)) begin errors++; $display("FAIL rnd_pkt_cnt got %0d want %0d", pkt_cnt, npk); end
    checks++; if (err_seen !== nstray) begin errors++; $display("FAIL rnd_err_cnt got %0d want %0d", err_seen, nstray); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single_flit;
    test_backpressure;
    test_stray;
    test_grant_stall;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
